// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index and the pipeline-control run state.
package cpu_types_pkg;
    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; one-cycle update on inc.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pipeline_control.sv
// Hazard resolution for the 5-stage pipe: latch enable/flush pairs and PC enable are
// combinational from state and hazards; halt drain FSM and perf counters are registered.
module pipeline_control
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memdREN,
    input  logic             memdWEN,
    input  logic             memBrTaken,
    input  logic             exMemRead,
    input  regbits_t         exwsel,
    input  regbits_t         idrs,
    input  regbits_t         idrt,
    input  logic             iduseRt,
    input  logic             idHALT,
    input  logic             wbcuHALT,
    output logic             pcW,
    output logic             ifidW,
    output logic             ifidRST,
    output logic             idexW,
    output logic             idexRST,
    output logic             exmemW,
    output logic             exmemRST,
    output logic             memwbW,
    output logic             memwbRST,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    pc_state_t state, next_state;
    logic      dpend, lu, stall_inc, flush_inc;

    assign dpend = (memdREN | memdWEN) & ~dhit;
    assign lu    = exMemRead && (exwsel != '0) &&
                   ((exwsel == idrs) || (iduseRt && (exwsel == idrt)));
    assign halt  = (state == HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        pcW        = 1'b0;
        ifidW      = 1'b0;
        ifidRST    = 1'b0;
        idexW      = 1'b0;
        idexRST    = 1'b0;
        exmemW     = 1'b0;
        exmemRST   = 1'b0;
        memwbW     = 1'b0;
        memwbRST   = 1'b0;
        case (state)
            RUN, DRAIN: begin
                pcW    = 1'b1;
                ifidW  = 1'b1;
                idexW  = 1'b1;
                exmemW = 1'b1;
                memwbW = 1'b1;
                if (dpend) begin
                    pcW       = 1'b0;
                    ifidW     = 1'b0;
                    idexW     = 1'b0;
                    exmemW    = 1'b0;
                    memwbRST  = 1'b1;
                    stall_inc = 1'b1;
                end else if (memBrTaken) begin
                    ifidRST   = 1'b1;
                    idexRST   = 1'b1;
                    exmemRST  = 1'b1;
                    flush_inc = 1'b1;
                end else if (lu) begin
                    pcW       = 1'b0;
                    ifidW     = 1'b0;
                    idexRST   = 1'b1;
                    stall_inc = 1'b1;
                end else if (!ihit) begin
                    pcW       = 1'b0;
                    ifidRST   = 1'b1;
                    stall_inc = 1'b1;
                end
                // While draining nothing new is fetched; a taken branch still redirects.
                if ((state == DRAIN) && !flush_inc) begin
                    pcW = 1'b0;
                    if (ifidW) ifidRST = 1'b1;
                end

                if (wbcuHALT) begin
                    next_state = HALTED;
                end else if (state == RUN) begin
                    if (idHALT && !memBrTaken && !dpend && !lu) next_state = DRAIN;
                end else if (memBrTaken) begin
                    next_state = RUN;
                end
            end
            HALTED: next_state = HALTED;
            default: next_state = RUN;
        endcase
        if (!nRST) begin
            pcW      = 1'b0;
            ifidW    = 1'b0;
            ifidRST  = 1'b0;
            idexW    = 1'b0;
            idexRST  = 1'b0;
            exmemW   = 1'b0;
            exmemRST = 1'b0;
            memwbW   = 1'b0;
            memwbRST = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );
endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Drives the write-enable/flush pairs (xW, xRST) of the four pipeline latches and the PC write enable in the 5-stage MIPS datapath.
- The MEM/WB latch only samples when its W is high and loads a bubble when RST is also high; this block is the producer of those controls.
- Resolves data-memory wait, taken-branch/jump flush, load-use stall, I-fetch miss and halt drain.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- memdREN  in  1  MEM-stage load request
- memdWEN  in  1  MEM-stage store request
- memBrTaken  in  1  branch/jump resolved taken in MEM
- exMemRead  in  1  EX-stage instruction is a load
- exwsel  in  5  EX-stage destination register
- idrs, idrt  in  5 each  ID-stage source registers
- iduseRt  in  1  ID instruction reads rt
- idHALT  in  1  HALT decoded in ID
- wbcuHALT  in  1  HALT in WB
- pcW  out  1  PC write enable
- ifidW, ifidRST, idexW, idexRST, exmemW, exmemRST, memwbW, memwbRST  out  1 each  latch enable/flush
- halt  out  1  sticky processor-halted flag
- stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- FSM states RUN, DRAIN, HALTED; reset state RUN.
- Reset values: halt=0, counters=0. While nRST is low, all W/RST outputs are 0.
- All W/RST outputs are combinational from the current state and inputs. The state and counters update on posedge CLK.
- dpend = (memdREN|memdWEN) & ~dhit.
- lu = exMemRead & exwsel!=0 & (exwsel==idrs | (iduseRt & exwsel==idrt)).
- Priority in RUN and DRAIN, highest first:
  1. dpend: pcW=0, ifidW=idexW=exmemW=0, memwbW=1, memwbRST=1 (bubble into WB).
  2. memBrTaken: pcW=1; ifid/idex/exmem W=1, RST=1; memwbW=1, memwbRST=0. The flush happens regardless of ihit.
  3. lu: pcW=0, ifidW=0, idexW=1, idexRST=1; exmem and memwb advance (W=1, RST=0).
  4. ~ihit: pcW=0, ifidW=1, ifidRST=1; later stages advance.
  5. Otherwise: all W=1, all RST=0, pcW=1.
- DRAIN forces pcW=0 and turns any ifid advance into ifidW=1, ifidRST=1 (no new fetch enters), except a taken branch, which takes rule 2 unchanged.
- Transitions:
  - RUN->DRAIN when idHALT & ~memBrTaken & ~dpend & ~lu (HALT leaves ID).
  - DRAIN->RUN on memBrTaken: the HALT was on a squashed path.
  - DRAIN->HALTED when wbcuHALT. wbcuHALT in RUN also goes to HALTED.
- HALTED: every W=0, every RST=0, pcW=0, halt=1. Exit only by reset.
- Counters saturate at all-ones with no wrap, and hold in HALTED.
  - stall_cnt +1 on each cycle that rule 1, 3 or 4 fires.
  - flush_cnt +1 on each cycle rule 2 fires.
  - A cycle with dpend & memBrTaken counts only as a stall. The branch stays asserted and flushes on the first cycle dpend drops.
- Reset mid-operation: asynchronous return to RUN, counters cleared, halt cleared.
- Register 0 never causes lu.

Decomposition:
- cpu_types_pkg gains pc_state_t enum {RUN, DRAIN, HALTED}. regbits_t (5-bit) already exists there and is used for register ports.
- One sub-module, sat_counter (parameter CNT_W; inc, count), instantiated twice.

Test Plan:
- memdREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles with pcW=0, exmemW=0, memwbW=1, memwbRST=1; cycle 4 all W=1, RST=0; stall_cnt=3.
- exMemRead=1, exwsel=8, idrs=8 → pcW=0, ifidW=0, idexW=1, idexRST=1, stall_cnt+1. Repeat with exwsel=0 → no stall.
- memBrTaken=1 with dpend=1 for 2 cycles → stall only, flush_cnt=0. Next cycle ifid/idex/exmem RST=1, pcW=1, flush_cnt=1.
- idHALT pulse → DRAIN, pcW=0, ifidRST=1 each cycle. wbcuHALT 3 cycles later → HALTED, halt=1, all W=0, counters frozen.
- In DRAIN, memBrTaken=1 → back to RUN, pcW=1, no halt.
- Preload stall_cnt to 2^CNT_W-1 (CNT_W=4, 15 stall cycles) then stall → stays 15. Assert nRST low mid-stall → counters 0, state RUN, outputs 0.
